// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler that time-shares one external 8x8->16
// combinational multiplier among NUM_REQ requesters.
//
// Two-stage pipeline:
//   S1 {a, b, id}    drives mul_a/mul_b to the external multiplier.
//   S2 {mul_o, id}   drives resp_prod/resp_id; resp_valid = s2_valid.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready is one-hot or zero)
//   req_a, req_b           packed operands, requester i at [8i+7:8i]
//   mul_a, mul_b, mul_o    external multiplier interface
//   resp_valid/resp_ready  response handshake; resp_id, resp_prod payload
//   busy                   either pipeline stage occupied
//   done_cnt               wrapping count of completed responses
module mul_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_o,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_prod,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);

  logic            s1_valid;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic [ID_W-1:0] s1_id;
  logic            s2_valid;
  logic [ID_W-1:0] s2_id;
  logic [15:0]     s2_prod;
  logic [ID_W-1:0] rr_ptr;

  logic            s2_free;
  logic            s1_move;
  logic            s1_free;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] grant;
  int unsigned     idx;

  always_comb begin
    s2_free = !s2_valid || resp_ready;
    s1_move = s1_valid && s2_free;
    s1_free = !s1_valid || s1_move;

    // Circular search starting at rr_ptr; first valid requester wins.
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < 32'(NUM_REQ); k++) begin
      idx = (32'(rr_ptr) + k) % 32'(NUM_REQ);
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    accept    = s1_free && found && rst_n;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a[32'(grant)*8 +: 8];
      s1_b     <= req_b[32'(grant)*8 +: 8];
      s1_id    <= grant;
      rr_ptr   <= ID_W'((32'(grant) + 32'd1) % 32'(NUM_REQ));
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_prod  <= '0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      s2_id    <= s1_id;
      s2_prod  <= mul_o;
    end else if (resp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (s2_valid && resp_ready) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

  assign mul_a      = s1_a;
  assign mul_b      = s1_b;
  assign resp_valid = s2_valid;
  assign resp_id    = s2_id;
  assign resp_prod  = s2_prod;
  assign busy       = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*8-1:0] req_a;
  logic [NR*8-1:0] req_b;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic [15:0]     mul_o;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [15:0]     resp_prod;
  logic            busy;
  logic [CW-1:0]   done_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Golden approximate multiplier used both as the external multiplier and
  // as the expectation; deliberately asymmetric so swapped operands show up.
  function automatic logic [15:0] gm(input logic [7:0] a, input logic [7:0] b);
    return (16'(a) * 16'(b)) ^ {4'h0, a, 4'h0};
  endfunction

  assign mul_o = gm(mul_a, mul_b);

  mul_share_sched #(.NUM_REQ(NR), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_prod(resp_prod),
    .busy(busy), .done_cnt(done_cnt)
  );

  // Reference model: in-order queue of accepted operations, at most two in
  // flight; the oldest becomes visible one edge after it was accepted.
  typedef struct packed {
    logic [IW-1:0] id;
    logic [15:0]   prod;
  } ent_t;

  ent_t          q[$];
  bit            s2_has;
  int            rr;
  int            exp_cnt;
  int            completions;
  int            m_s1_occ;
  bit            m_s2_free;
  int            m_g;
  logic [NR-1:0] exp_ready;
  logic          exp_rv;
  logic [IW-1:0] exp_id;
  logic [15:0]   exp_prod;
  logic          exp_busy;
  logic [7:0]    pa[NR];
  logic [7:0]    pb[NR];

  task automatic model_reset();
    q.delete();
    s2_has = 0; rr = 0; exp_cnt = 0; completions = 0;
  endtask

  task automatic model_eval();
    bit s1_free;
    exp_rv = s2_has;
    if (s2_has) begin
      exp_id   = q[0].id;
      exp_prod = q[0].prod;
    end
    exp_busy  = (q.size() != 0);
    m_s1_occ  = q.size() - (s2_has ? 1 : 0);
    m_s2_free = !s2_has || resp_ready;
    s1_free   = (m_s1_occ == 0) || m_s2_free;
    m_g = -1;
    if (s1_free && rst_n)
      for (int k = 0; k < NR; k++)
        if (m_g < 0 && req_valid[(rr + k) % NR]) m_g = (rr + k) % NR;
    exp_ready = (m_g >= 0) ? (4'(1) << m_g) : '0;
  endtask

  task automatic model_edge();
    bit s2_old;
    s2_old = s2_has;
    if (s2_has && resp_ready) begin
      void'(q.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      completions++;
    end
    s2_has = (s2_old && !resp_ready) || (m_s1_occ == 1 && m_s2_free);
    if (m_g >= 0) begin
      q.push_back('{id: IW'(m_g), prod: gm(pa[m_g], pb[m_g])});
      rr = (m_g + 1) % NR;
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*8 +: 8] = pa[i];
      req_b[i*8 +: 8] = pb[i];
    end
  endtask

  // Advance one clock: model follows the same edge, an accepted requester
  // presents fresh random operands afterwards.
  task automatic tick();
    model_eval();
    model_edge();
    if (m_g >= 0) begin
      pa[m_g] = 8'($urandom);
      pb[m_g] = 8'($urandom);
    end
    @(posedge clk);
    #1;
    drive_ops();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; resp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    drive_ops();
    model_reset();
    #12;
    nchk++; if (req_ready !== '0) begin nerr++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    nchk++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL reset_valid_busy got=%b%b want=00", resp_valid, busy); end
    nchk++; if ({mul_a, mul_b} !== 16'h0) begin nerr++; $display("FAIL reset_mul got=%h want=0000", {mul_a, mul_b}); end
    nchk++; if ({resp_id, resp_prod, done_cnt} !== '0) begin nerr++; $display("FAIL reset_resp got=%h/%h/%h want=0", resp_id, resp_prod, done_cnt); end
    req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] av[2] = '{8'hFF, 8'h00};
    logic [7:0] bv[2] = '{8'hFF, 8'h37};
    for (int t = 0; t < 2; t++) begin
      pa[2] = av[t]; pb[2] = bv[t]; drive_ops();
      req_valid = 4'b0100; resp_ready = 1'b1;
      #1;
      nchk++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_grant got=%b want=0100", req_ready); end
      tick();
      req_valid = '0;
      #1;
      nchk++; if (resp_valid !== 1'b0 || mul_a !== av[t] || mul_b !== bv[t]) begin
        nerr++; $display("FAIL single_s1 got=%b/%h/%h want=0/%h/%h", resp_valid, mul_a, mul_b, av[t], bv[t]);
      end
      tick();
      #1;
      nchk++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_prod !== gm(av[t], bv[t])) begin
        nerr++; $display("FAIL single_resp got=%b/%0d/%h want=1/2/%h", resp_valid, resp_id, resp_prod, gm(av[t], bv[t]));
      end
      if (t == 1) begin
        nchk++; if (resp_prod !== 16'h0000) begin nerr++; $display("FAIL single_zero got=%h want=0000", resp_prod); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int start;
    req_valid = '1; resp_ready = 1'b1;
    #1; model_eval();
    start = rr;
    for (int c = 0; c < 12; c++) begin
      #1; model_eval();
      nchk++; if (req_ready !== 4'(1 << ((start + c) % NR))) begin
        nerr++; $display("FAIL rr_order cyc=%0d got=%b want=%b", c, req_ready, 4'(1 << ((start + c) % NR)));
      end
      nchk++; if (resp_valid !== exp_rv || (c >= 2 && resp_valid !== 1'b1)) begin
        nerr++; $display("FAIL rr_valid cyc=%0d got=%b want=%b", c, resp_valid, exp_rv);
      end
      if (exp_rv) begin
        nchk++; if (resp_id !== exp_id || resp_prod !== exp_prod) begin
          nerr++; $display("FAIL rr_resp cyc=%0d got=%0d/%h want=%0d/%h", c, resp_id, resp_prod, exp_id, exp_prod);
        end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_rr_skip();
    req_valid = 4'b0010; resp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL skip_first got=%b want=0010", req_ready); end
    tick();
    req_valid = 4'b1001;
    #1;
    nchk++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL skip_three got=%b want=1000", req_ready); end
    tick();
    #1;
    nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL skip_zero got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] hold_id;
    logic [15:0]   hold_prod;
    req_valid = '1; resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1; model_eval();
      if (c >= 2) begin
        nchk++; if (req_ready !== '0 || busy !== 1'b1) begin nerr++; $display("FAIL bp_stall cyc=%0d got=%b/%b want=0000/1", c, req_ready, busy); end
      end
      nchk++; if (req_ready !== exp_ready || resp_valid !== exp_rv) begin
        nerr++; $display("FAIL bp_hs cyc=%0d got=%b/%b want=%b/%b", c, req_ready, resp_valid, exp_ready, exp_rv);
      end
      if (c == 2) begin hold_id = resp_id; hold_prod = resp_prod; end
      if (c > 2) begin
        nchk++; if (resp_id !== hold_id || resp_prod !== hold_prod) begin
          nerr++; $display("FAIL bp_stable cyc=%0d got=%0d/%h want=%0d/%h", c, resp_id, resp_prod, hold_id, hold_prod);
        end
      end
      tick();
    end
    req_valid = '0; resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; model_eval();
      nchk++; if (resp_valid !== exp_rv || (exp_rv && (resp_id !== exp_id || resp_prod !== exp_prod))) begin
        nerr++; $display("FAIL bp_drain cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", c, resp_valid, resp_id, resp_prod, exp_rv, exp_id, exp_prod);
      end
      nchk++; if (done_cnt !== CW'(exp_cnt)) begin nerr++; $display("FAIL bp_cnt got=%0d want=%0d", done_cnt, exp_cnt); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    req_valid = '1; resp_ready = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0; req_valid = '0;
    model_reset();
    #1;
    nchk++; if (resp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== '0) begin
      nerr++; $display("FAIL mid_reset got=%b/%b/%0d want=0/0/0", resp_valid, busy, done_cnt);
    end
    @(posedge clk); #3 rst_n = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      #1;
      nchk++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL mid_ghost cyc=%0d got=%b/%b want=0/0", c, resp_valid, busy); end
      tick();
    end
  endtask

  task automatic test_wrap_random();
    int budget = 0;
    #2 rst_n = 1'b0; model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    while (completions < 20 && budget < 300) begin
      req_valid  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      #1; model_eval();
      nchk++; if (req_ready !== exp_ready || resp_valid !== exp_rv || busy !== exp_busy) begin
        nerr++; $display("FAIL rnd_hs got=%b/%b/%b want=%b/%b/%b", req_ready, resp_valid, busy, exp_ready, exp_rv, exp_busy);
      end
      if (exp_rv) begin
        nchk++; if (resp_id !== exp_id || resp_prod !== exp_prod) begin
          nerr++; $display("FAIL rnd_resp got=%0d/%h want=%0d/%h", resp_id, resp_prod, exp_id, exp_prod);
        end
      end
      nchk++; if (done_cnt !== CW'(exp_cnt)) begin nerr++; $display("FAIL rnd_cnt got=%0d want=%0d", done_cnt, exp_cnt); end
      tick();
      budget++;
    end
    nchk++; if (completions < 20) begin nerr++; $display("FAIL rnd_timeout got=%0d want=20 completions", completions); end
    #1;
    nchk++; if (done_cnt !== 4'd4) begin nerr++; $display("FAIL wrap_cnt got=%0d want=4", done_cnt); end
    req_valid = '0; resp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_backpressure();
    test_reset_midstream();
    test_wrap_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
